clock_sys_rst_seq: RTL and testbench



---
 rtl/clock_sys_pkg.sv | 21 ++
 rtl/sync_ff.sv | 24 ++
 rtl/clock_sys_rst_seq.sv | 168 ++++++++++++++++
 tb/tb_clock_sys_rst_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_sys_pkg.sv
// Shared types and sizing helpers for the system-clock lock monitor and reset sequencer.
package clock_sys_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    HOLD      = 3'd4
  } state_t;

  // One shared counter times qualification, stagger and hold, so size it for the longest.
  function automatic int cnt_width(input int stable_c, input int stagger_c, input int min_rst_c);
    int m;
    m = stable_c;
    if (stagger_c > m) m = stagger_c;
    if (min_rst_c > m) m = min_rst_c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for slow level signals crossing into a clock domain.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clock_sys_rst_seq.sv
// PLL lock qualifier and ordered, staggered release of domain resets on clk_sys,
// with immediate re-assertion and lock-loss statistics.
module clock_sys_rst_seq
  import clock_sys_pkg::*;
#(
  parameter int NUM_RST        = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES = 16,
  parameter int MIN_RST_CYCLES = 8,
  parameter int CNT_W          = 8
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic               pll_lock_async,
  input  logic               sw_rst,
  input  logic               clr_stats,
  output logic [NUM_RST-1:0] rst_out_n,
  output logic               locked,
  output logic               lock_lost_sticky,
  output logic [CNT_W-1:0]   lock_loss_cnt
);

  localparam int CW    = cnt_width(STABLE_CYCLES, STAGGER_CYCLES, MIN_RST_CYCLES);
  localparam int IDX_W = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

  localparam logic [CW-1:0]    STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]    STAGGER_LAST = CW'(STAGGER_CYCLES - 1);
  localparam logic [CW-1:0]    HOLD_LAST    = CW'(MIN_RST_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_RST - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

  logic               lock_s;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_RST-1:0] rst_q, rst_d;
  logic               locked_q, locked_d;
  logic               sticky_q, sticky_d;
  logic [CNT_W-1:0]   lcnt_q, lcnt_d;

  logic active, loss, abort, stable_done, stagger_done;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk_sys),
    .rst_n (rst_n),
    .d_i   (pll_lock_async),
    .q_o   (lock_s)
  );

  // Loss wins over sw_rst when both appear, so it is always counted.
  assign active       = (state_q == RELEASE) || (state_q == RUN);
  assign loss         = active && !lock_s;
  assign abort        = active && (!lock_s || sw_rst);
  assign stable_done  = (state_q == STABLE) && lock_s && !sw_rst && (cnt_q == STABLE_LAST);
  assign stagger_done = (state_q == RELEASE) && !abort && (cnt_q == STAGGER_LAST);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_LOCK;
      cnt_q    <= '0;
      idx_q    <= '0;
      rst_q    <= '0;
      locked_q <= 1'b0;
      sticky_q <= 1'b0;
      lcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rst_q    <= rst_d;
      locked_q <= locked_d;
      sticky_q <= sticky_d;
      lcnt_q   <= lcnt_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned and infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s && !sw_rst) state_d = STABLE;
      end
      STABLE: begin
        if (!lock_s || sw_rst) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (stable_done) begin
          state_d = (NUM_RST == 1) ? RUN : RELEASE;
          cnt_d   = '0;
          idx_d   = IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        if (abort) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (stagger_done) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) state_d = RUN;
          else                   idx_d   = idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        if (abort) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    rst_d    = rst_q;
    locked_d = locked_q;
    if (abort) begin
      rst_d    = '0;
      locked_d = 1'b0;
    end else if (stable_done) begin
      rst_d[0] = 1'b1;
      if (NUM_RST == 1) locked_d = 1'b1;
    end else if (stagger_done) begin
      for (int k = 0; k < NUM_RST; k++) begin
        if (idx_q == IDX_W'(k)) rst_d[k] = 1'b1;
      end
      if (idx_q == IDX_LAST) locked_d = 1'b1;
    end

    // A loss on the same edge as a clear survives as the first event after the clear.
    sticky_d = sticky_q;
    lcnt_d   = lcnt_q;
    if (clr_stats) begin
      sticky_d = loss;
      lcnt_d   = loss ? CNT_W'(1) : '0;
    end else if (loss) begin
      sticky_d = 1'b1;
      if (lcnt_q != CNT_MAX) lcnt_d = lcnt_q + CNT_W'(1);
    end
  end

  assign rst_out_n        = rst_q;
  assign locked           = locked_q;
  assign lock_lost_sticky = sticky_q;
  assign lock_loss_cnt    = lcnt_q;

endmodule

// File: tb/tb_clock_sys_rst_seq.sv
// Directed bench for the lock monitor / reset sequencer with small timing parameters.
module tb_clock_sys_rst_seq;

  localparam int NUM_RST = 3;
  localparam int CNT_W   = 2;

  logic               clk_sys = 1'b0;
  logic               rst_n;
  logic               pll_lock_async;
  logic               sw_rst;
  logic               clr_stats;
  logic [NUM_RST-1:0] rst_out_n;
  logic               locked;
  logic               lock_lost_sticky;
  logic [CNT_W-1:0]   lock_loss_cnt;

  int checks = 0;
  int errors = 0;

  int rise [NUM_RST];
  int lk_rise;
  bit bad_order;

  clock_sys_rst_seq #(
    .NUM_RST        (NUM_RST),
    .SYNC_STAGES    (2),
    .STABLE_CYCLES  (16),
    .STAGGER_CYCLES (4),
    .MIN_RST_CYCLES (8),
    .CNT_W          (CNT_W)
  ) dut (
    .clk_sys          (clk_sys),
    .rst_n            (rst_n),
    .pll_lock_async   (pll_lock_async),
    .sw_rst           (sw_rst),
    .clr_stats        (clr_stats),
    .rst_out_n        (rst_out_n),
    .locked           (locked),
    .lock_lost_sticky (lock_lost_sticky),
    .lock_loss_cnt    (lock_loss_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // Records the edge (counted from the call) at which each output first rises;
  // flags any out-of-order pattern or locked disagreeing with the resets.
  task automatic measure(input int stop_bit, input int budget);
    for (int k = 0; k < NUM_RST; k++) rise[k] = -1;
    lk_rise   = -1;
    bad_order = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk_sys);
      #1;
      for (int k = 0; k < NUM_RST; k++) begin
        if (rise[k] < 0 && rst_out_n[k] === 1'b1) rise[k] = i;
      end
      if (lk_rise < 0 && locked === 1'b1) lk_rise = i;
      if (!(rst_out_n inside {3'b000, 3'b001, 3'b011, 3'b111})) bad_order = 1'b1;
      if (locked !== (&rst_out_n)) bad_order = 1'b1;
      if (rst_out_n[stop_bit] === 1'b1) break;
    end
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_lock_async = 1'b1; sw_rst = 1'b0; clr_stats = 1'b0;
    step(4);
    checks++; if (rst_out_n !== 3'b000) begin errors++; $display("FAIL reset_rst_out_n got %b exp 000", rst_out_n); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", locked); end
    checks++; if (lock_lost_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b exp 0", lock_lost_sticky); end
    checks++; if (lock_loss_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", lock_loss_cnt); end
    pll_lock_async = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(5);
    checks++; if (rst_out_n !== 3'b000) begin errors++; $display("FAIL idle_no_lock got %b exp 000", rst_out_n); end
  endtask

  task automatic test_clean_start();
    pll_lock_async = 1'b1;
    measure(2, 60);
    checks++; if (rise[0] != 19) begin errors++; $display("FAIL clean_rise0 got %0d exp 19", rise[0]); end
    checks++; if (rise[1] != 23) begin errors++; $display("FAIL clean_rise1 got %0d exp 23", rise[1]); end
    checks++; if (rise[2] != 27) begin errors++; $display("FAIL clean_rise2 got %0d exp 27", rise[2]); end
    checks++; if (lk_rise != 27) begin errors++; $display("FAIL clean_locked got %0d exp 27", lk_rise); end
    checks++; if (bad_order) begin errors++; $display("FAIL clean_order got bad exp ordered"); end
  endtask

  task automatic test_lock_glitch();
    pll_lock_async = 1'b0;
    do_reset();
    step(2);
    pll_lock_async = 1'b1;
    step(10);
    pll_lock_async = 1'b0;
    step(3);
    checks++; if (rst_out_n !== 3'b000) begin errors++; $display("FAIL glitch_no_release got %b exp 000", rst_out_n); end
    pll_lock_async = 1'b1;
    measure(2, 60);
    checks++; if (rise[0] != 19) begin errors++; $display("FAIL glitch_rise0 got %0d exp 19", rise[0]); end
    checks++; if (rise[2] != 27) begin errors++; $display("FAIL glitch_rise2 got %0d exp 27", rise[2]); end
    checks++; if (lock_loss_cnt !== 2'd0) begin errors++; $display("FAIL glitch_cnt got %0d exp 0", lock_loss_cnt); end
    checks++; if (lock_lost_sticky !== 1'b0) begin errors++; $display("FAIL glitch_sticky got %b exp 0", lock_lost_sticky); end
  endtask

  task automatic test_lock_loss_run();
    step(2);
    pll_lock_async = 1'b0;
    step(2);
    checks++; if (rst_out_n !== 3'b111) begin errors++; $display("FAIL loss_before got %b exp 111", rst_out_n); end
    step(1);
    checks++; if (rst_out_n !== 3'b000) begin errors++; $display("FAIL loss_rst got %b exp 000", rst_out_n); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL loss_locked got %b exp 0", locked); end
    checks++; if (lock_lost_sticky !== 1'b1) begin errors++; $display("FAIL loss_sticky got %b exp 1", lock_lost_sticky); end
    checks++; if (lock_loss_cnt !== 2'd1) begin errors++; $display("FAIL loss_cnt got %0d exp 1", lock_loss_cnt); end
    pll_lock_async = 1'b1;
    measure(2, 80);
    checks++; if (rise[0] != 25) begin errors++; $display("FAIL loss_rise0 got %0d exp 25", rise[0]); end
    checks++; if (rise[1] != 29) begin errors++; $display("FAIL loss_rise1 got %0d exp 29", rise[1]); end
    checks++; if (rise[2] != 33) begin errors++; $display("FAIL loss_rise2 got %0d exp 33", rise[2]); end
    checks++; if (bad_order) begin errors++; $display("FAIL loss_order got bad exp ordered"); end
  endtask

  task automatic test_sw_rst_release();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (lock_lost_sticky !== 1'b0) begin errors++; $display("FAIL async_sticky got %b exp 0", lock_lost_sticky); end
    checks++; if (lock_loss_cnt !== 2'd0) begin errors++; $display("FAIL async_cnt got %0d exp 0", lock_loss_cnt); end
    step(1);
    rst_n = 1'b1;
    measure(0, 60);
    checks++; if (rise[0] != 19) begin errors++; $display("FAIL sw_pre_rise0 got %0d exp 19", rise[0]); end
    sw_rst = 1'b1;
    step(1);
    sw_rst = 1'b0;
    checks++; if (rst_out_n !== 3'b000) begin errors++; $display("FAIL sw_rst_out got %b exp 000", rst_out_n); end
    checks++; if (lock_lost_sticky !== 1'b0) begin errors++; $display("FAIL sw_sticky got %b exp 0", lock_lost_sticky); end
    checks++; if (lock_loss_cnt !== 2'd0) begin errors++; $display("FAIL sw_cnt got %0d exp 0", lock_loss_cnt); end
    measure(2, 80);
    checks++; if (rise[0] != 25) begin errors++; $display("FAIL sw_rise0 got %0d exp 25", rise[0]); end
    checks++; if (rise[2] != 33) begin errors++; $display("FAIL sw_rise2 got %0d exp 33", rise[2]); end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      measure(0, 80);
      checks++; if (rise[0] < 0) begin errors++; $display("FAIL sat_reach%0d got timeout exp release", i); end
      pll_lock_async = 1'b0;
      step(3);
      exp_cnt = (i > 3) ? 3 : i;
      checks++; if (lock_loss_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL sat_cnt%0d got %0d exp %0d", i, lock_loss_cnt, exp_cnt); end
      pll_lock_async = 1'b1;
    end
    checks++; if (lock_lost_sticky !== 1'b1) begin errors++; $display("FAIL sat_sticky got %b exp 1", lock_lost_sticky); end
    measure(0, 80);
    pll_lock_async = 1'b0;
    step(2);
    clr_stats = 1'b1;
    step(1);
    clr_stats = 1'b0;
    pll_lock_async = 1'b1;
    checks++; if (lock_loss_cnt !== 2'd1) begin errors++; $display("FAIL clr_loss_cnt got %0d exp 1", lock_loss_cnt); end
    checks++; if (lock_lost_sticky !== 1'b1) begin errors++; $display("FAIL clr_loss_sticky got %b exp 1", lock_lost_sticky); end
    step(4);
    clr_stats = 1'b1;
    step(1);
    clr_stats = 1'b0;
    checks++; if (lock_loss_cnt !== 2'd0) begin errors++; $display("FAIL clr_cnt got %0d exp 0", lock_loss_cnt); end
    checks++; if (lock_lost_sticky !== 1'b0) begin errors++; $display("FAIL clr_sticky got %b exp 0", lock_lost_sticky); end
  endtask

  task automatic test_async_reset();
    do_reset();
    measure(1, 60);
    checks++; if (rst_out_n !== 3'b011) begin errors++; $display("FAIL mid_release got %b exp 011", rst_out_n); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rst_out_n !== 3'b000) begin errors++; $display("FAIL async_rst_out got %b exp 000", rst_out_n); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL async_locked got %b exp 0", locked); end
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_start();
    test_lock_glitch();
    test_lock_loss_run();
    test_sw_rst_release();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
